instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage between the program counter and decode. Drives the PC's inc/load controls.
//  Issues one instruction-memory read at a time, each at the current PC address.
//  Queues each returned instruction with its address in a DEPTH-entry FIFO.
//  Decode consumes the queue through a valid/ready handshake; a redirect (jump) flushes it.
// PARAMETERS
//  BUS_WIDTH    16  address width; matches the PC width
//  INSTR_WIDTH  16  instruction word width
//  DEPTH        2   FIFO entries; power of two, >= 2
// PORTS
//  clock            in   1            rising-edge clock
//  reset            in   1            asynchronous, active-high
//  pc_addr          in   BUS_WIDTH    current PC value (PC out)
//  pc_inc           out  1            PC inc control
//  pc_load          out  1            PC load control
//  pc_in            out  BUS_WIDTH    PC load value
//  imem_req         out  1            memory read request
//  imem_addr        out  BUS_WIDTH    read address
//  imem_ack         in   1            read data valid; may assert in the same cycle as imem_req
//  imem_data        in   INSTR_WIDTH  read data
//  redirect         in   1            jump taken; single-cycle pulse
//  redirect_target  in   BUS_WIDTH    jump address
//  instr_valid      out  1            FIFO head valid
//  instr_ready      in   1            decode accepts the head
//  instr            out  INSTR_WIDTH  head instruction
//  instr_pc         out  BUS_WIDTH    head address
// BEHAVIOUR
//  - Reset (async): FSM=IDLE, FIFO empty. All outputs 0 (instr_valid=0, imem_req=0, pc_* = 0).
//    The PC is reset by the same reset net; this block does not drive PC reset.
//  - FSM IDLE: imem_req = (count<DEPTH) & ~redirect; imem_addr = pc_addr.
//    On issue, req_addr <= pc_addr.
//      - if imem_ack arrives in the issue cycle, stay IDLE;
//      - otherwise go to REQ.
//  - FSM REQ: imem_req=1 and imem_addr=req_addr, both held stable until imem_ack.
//    On ack, go to IDLE.
//  - FSM DRAIN: same outputs as REQ. The acked data is discarded; on ack, go to IDLE.
//  - Accepted ack, without redirect:
//      - push {req_addr or pc_addr, imem_data} into the FIFO;
//      - pc_inc=1 in that same cycle (combinational), so PC = addr+1 at the next edge.
//  - Throughput: with zero-wait memory, 1 instruction per cycle.
//  - Latency: ack in cycle N -> instr_valid in cycle N+1.
//  - Pop: on instr_valid & instr_ready, at the edge.
//    Push and pop in the same cycle: count unchanged.
//    Overflow cannot occur: issue requires count<DEPTH and at most one request is outstanding.
//  - Redirect in cycle N:
//      - pc_load=1, pc_in=redirect_target, pc_inc=0 (combinational);
//      - FIFO cleared at the edge; a pop in cycle N is ignored;
//      - outstanding request not acked in N -> go to DRAIN;
//      - ack in N -> data discarded, go to IDLE;
//      - no new issue in N; the first fetch of the target is issued in N+1.
//  - Redirect while in DRAIN: stays in DRAIN; only the new target is loaded.
//  - imem_ack with imem_req=0: ignored.
//  - FIFO pointers: log2(DEPTH) bits, wrap modulo DEPTH.
//    count has log2(DEPTH)+1 bits, range 0..DEPTH.
//  - pc_in = 0 whenever pc_load=0.
//  - Reset asserted mid-request: FSM returns to IDLE, FIFO is cleared, and any late ack is ignored.
// CONFIGURATION
//  IFETCH_PERF_EN defined: adds two 32-bit outputs.
//    - perf_fetched: count of accepted, non-discarded acks.
//    - perf_stall: count of cycles with instr_valid & ~instr_ready.
//    - Both reset to 0 and wrap at 2^32.
//  IFETCH_PERF_EN undefined: these ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  1. Reset with pc_addr=0 and zero-wait memory (ack=req), ready=1:
//     instr_pc 0,1,2,3 on consecutive cycles; pc_inc=1 each cycle.
//  2. ready=0, zero-wait memory, DEPTH=2:
//     exactly 2 pushes, then imem_req=0 and pc_inc=0 hold.
//     Raise ready: head instr_pc=0, refill resumes.
//  3. Memory ack delayed 3 cycles:
//     imem_req and imem_addr held stable for 3 cycles; instr_valid one cycle after ack.
//  4. redirect=1, target=0x0040, while a request to 0x0005 is outstanding:
//     pc_load=1 and pc_in=0x0040; FIFO cleared; the 0x0005 ack is discarded;
//     the next instr_pc is 0x0040.
//  5. redirect in the same cycle as ack and pop:
//     no push, no pc_inc, instr_valid=0 at the next cycle.
//  6. Assert reset while in REQ, then ack arrives: ignored; instr_valid=0.
//     With IFETCH_PERF_EN, perf_fetched=0.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC control, single-outstanding imem reads, instruction FIFO to decode
// Optional feature macro: IFETCH_PERF_EN (adds perf_fetched / perf_stall counters)
module instr_fetch #(
   parameter int BUS_WIDTH   = 16,
   parameter int INSTR_WIDTH = 16,
   parameter int DEPTH       = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [BUS_WIDTH-1:0]   pc_addr,
   output logic                   pc_inc,
   output logic                   pc_load,
   output logic [BUS_WIDTH-1:0]   pc_in,
   output logic                   imem_req,
   output logic [BUS_WIDTH-1:0]   imem_addr,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] imem_data,
   input  logic                   redirect,
   input  logic [BUS_WIDTH-1:0]   redirect_target,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [BUS_WIDTH-1:0]   instr_pc
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]            perf_fetched,
   output logic [31:0]            perf_stall
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t                 state_q;
   logic [BUS_WIDTH-1:0]   req_addr_q;
   logic [BUS_WIDTH-1:0]   fifo_pc_q    [DEPTH];
   logic [INSTR_WIDTH-1:0] fifo_instr_q [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q;
   logic [PTR_W-1:0]       rd_ptr_q;
   logic [CNT_W-1:0]       count_q;
   logic [CNT_W-1:0]       count_d;

   logic                   active;
   logic                   issue;
   logic                   ack_acc;
   logic                   push;
   logic                   pop;
   logic [BUS_WIDTH-1:0]   push_pc;

   // Request/handshake decode; everything is forced quiet while reset is held
   always_comb begin
      active    = ~reset;
      issue     = active && (state_q == IDLE) && (count_q < DEPTH_C) && !redirect;
      imem_req  = active && ((state_q != IDLE) || issue);
      imem_addr = '0;
      if (active) begin
         imem_addr = (state_q == IDLE) ? pc_addr : req_addr_q;
      end
      ack_acc   = imem_req && imem_ack;
      push      = ack_acc && !redirect && (state_q != DRAIN);
      push_pc   = (state_q == IDLE) ? pc_addr : req_addr_q;
      pc_inc    = push;
      pc_load   = active && redirect;
      pc_in     = pc_load ? redirect_target : '0;
      pop       = instr_valid && instr_ready && !redirect;
      count_d   = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO head presentation; zero when empty so outputs stay clean after reset
   always_comb begin
      instr_valid = (count_q != '0);
      instr       = instr_valid ? fifo_instr_q[rd_ptr_q] : '0;
      instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]    : '0;
   end

   // Fetch FSM: at most one request outstanding; DRAIN swallows the ack of a killed request
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         req_addr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (issue) begin
                  req_addr_q <= pc_addr;
                  if (!imem_ack) state_q <= REQ;
               end
            end
            REQ: begin
               if (imem_ack)      state_q <= IDLE;
               else if (redirect) state_q <= DRAIN;
            end
            DRAIN: begin
               if (imem_ack) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // FIFO pointers and occupancy; a redirect empties the queue and overrides any pop
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (redirect) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // FIFO storage; contents are only meaningful under count_q, so no reset needed
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]    <= push_pc;
         fifo_instr_q[wr_ptr_q] <= imem_data;
      end
   end

`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched_q;
   logic [31:0] perf_stall_q;

   // Performance counters: delivered fetches and decode back-pressure cycles
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         if (push)                        perf_fetched_q <= perf_fetched_q + 32'd1;
         if (instr_valid && !instr_ready) perf_stall_q   <= perf_stall_q + 32'd1;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch (vector table + scoreboard + corner sequences)
module tb_instr_fetch;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] pc_addr;
   logic        pc_inc, pc_load;
   logic [15:0] pc_in;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic        redirect = 1'b0;
   logic [15:0] redirect_target = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [15:0] instr;
   logic [15:0] instr_pc;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stall;
`endif

   logic        zero_wait = 1'b1;
   logic        ack_drv   = 1'b0;
   logic [15:0] pc_q;

   int checks   = 0;
   int failures = 0;
   logic [15:0] sb_q[$];

   always #5 clock = ~clock;

   instr_fetch dut (
      .clock(clock), .reset(reset), .pc_addr(pc_addr),
      .pc_inc(pc_inc), .pc_load(pc_load), .pc_in(pc_in),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .redirect(redirect), .redirect_target(redirect_target),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef IFETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
   );

   // Program counter and instruction memory models
   always @(posedge clock or posedge reset) begin
      if (reset)        pc_q <= '0;
      else if (pc_load) pc_q <= pc_in;
      else if (pc_inc)  pc_q <= pc_q + 16'd1;
   end
   assign pc_addr   = pc_q;
   assign imem_ack  = zero_wait ? imem_req : ack_drv;
   assign imem_data = imem_addr ^ 16'hC3A5;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted head is compared with the next expected address
   always @(negedge clock) begin
      #2;
      if (!reset && instr_valid && instr_ready && !redirect) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_pop actual=%h required=none", instr_pc);
         end else begin
            logic [15:0] e;
            e = sb_q.pop_front();
            chk("sb_instr_pc", {16'h0, instr_pc}, {16'h0, e});
            chk("sb_instr", {16'h0, instr}, {16'h0, e ^ 16'hC3A5});
         end
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1; redirect = 1'b0; ack_drv = 1'b0;
      tick();
      tick();
   endtask

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        e_valid;
      logic [15:0] e_pc;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_inc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic rdy, input logic ev, input logic [15:0] epc,
                               input logic er, input logic [15:0] ea, input logic ei);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.e_valid = ev; v.e_pc = epc;
      v.e_req = er; v.e_addr = ea; v.e_inc = ei;
      return v;
   endfunction

   initial begin
      // zero-wait streaming, then back-pressure with DEPTH=2
      vecs.push_back(mk(1, 1, 0, 16'h0, 0, 16'h0, 0));
      vecs.push_back(mk(1, 1, 0, 16'h0, 0, 16'h0, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0, 1, 16'h0, 1));
      vecs.push_back(mk(0, 1, 1, 16'h0, 1, 16'h1, 1));
      vecs.push_back(mk(0, 1, 1, 16'h1, 1, 16'h2, 1));
      vecs.push_back(mk(0, 1, 1, 16'h2, 1, 16'h3, 1));
      vecs.push_back(mk(0, 1, 1, 16'h3, 1, 16'h4, 1));
      vecs.push_back(mk(1, 0, 0, 16'h0, 0, 16'h0, 0));
      vecs.push_back(mk(1, 0, 0, 16'h0, 0, 16'h0, 0));
      vecs.push_back(mk(0, 0, 0, 16'h0, 1, 16'h0, 1));
      vecs.push_back(mk(0, 0, 1, 16'h0, 1, 16'h1, 1));
      vecs.push_back(mk(0, 0, 1, 16'h0, 0, 16'h0, 0));
      vecs.push_back(mk(0, 0, 1, 16'h0, 0, 16'h0, 0));
      vecs.push_back(mk(0, 1, 1, 16'h0, 0, 16'h0, 0));
      vecs.push_back(mk(0, 1, 1, 16'h1, 1, 16'h2, 1));
      vecs.push_back(mk(0, 1, 1, 16'h2, 1, 16'h3, 1));
      foreach (vecs[i]) begin end
      sb_q = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h0, 16'h1, 16'h2};

      zero_wait = 1'b1;
      foreach (vecs[i]) begin
         tick();
         reset = vecs[i].rst;
         instr_ready = vecs[i].rdy;
         #1;
         chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
         if (vecs[i].e_valid) chk($sformatf("v%0d_pc", i), {16'h0, instr_pc}, {16'h0, vecs[i].e_pc});
         chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
         if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), {16'h0, imem_addr}, {16'h0, vecs[i].e_addr});
         chk($sformatf("v%0d_inc", i), {31'h0, pc_inc}, {31'h0, vecs[i].e_inc});
         if (vecs[i].rst) chk($sformatf("v%0d_load", i), {31'h0, pc_load}, 32'h0);
      end

      // ack delayed three cycles
      do_reset();
      zero_wait = 1'b0; instr_ready = 1'b1;
      sb_q.push_back(16'h0);
      tick(); reset = 1'b0; #1;
      chk("slow_c0_req", {31'h0, imem_req}, 32'h1);
      chk("slow_c0_addr", {16'h0, imem_addr}, 32'h0);
      for (int k = 1; k < 3; k++) begin
         tick(); #1;
         chk($sformatf("slow_c%0d_req", k), {31'h0, imem_req}, 32'h1);
         chk($sformatf("slow_c%0d_addr", k), {16'h0, imem_addr}, 32'h0);
         chk($sformatf("slow_c%0d_inc", k), {31'h0, pc_inc}, 32'h0);
         chk($sformatf("slow_c%0d_valid", k), {31'h0, instr_valid}, 32'h0);
      end
      tick(); ack_drv = 1'b1; #1;
      chk("slow_ack_addr", {16'h0, imem_addr}, 32'h0);
      chk("slow_ack_inc", {31'h0, pc_inc}, 32'h1);
      chk("slow_ack_valid", {31'h0, instr_valid}, 32'h0);
      tick(); ack_drv = 1'b0; #1;
      chk("slow_next_valid", {31'h0, instr_valid}, 32'h1);
      chk("slow_next_pc", {16'h0, instr_pc}, 32'h0);

      // redirect while a request to 0x0005 is outstanding
      do_reset();
      zero_wait = 1'b0; instr_ready = 1'b1;
      sb_q.push_back(16'h0040);
      tick(); reset = 1'b0; redirect = 1'b1; redirect_target = 16'h0005; #1;
      chk("r5_load", {31'h0, pc_load}, 32'h1);
      chk("r5_pc_in", {16'h0, pc_in}, 32'h5);
      chk("r5_req", {31'h0, imem_req}, 32'h0);
      tick(); redirect = 1'b0; #1;
      chk("r5_pc_in_idle", {16'h0, pc_in}, 32'h0);
      chk("r5_issue_addr", {16'h0, imem_addr}, 32'h5);
      tick(); redirect = 1'b1; redirect_target = 16'h0040; #1;
      chk("r40_load", {31'h0, pc_load}, 32'h1);
      chk("r40_pc_in", {16'h0, pc_in}, 32'h40);
      chk("r40_inc", {31'h0, pc_inc}, 32'h0);
      chk("r40_hold_addr", {16'h0, imem_addr}, 32'h5);
      tick(); redirect = 1'b0; ack_drv = 1'b1; #1;
      chk("drain_req", {31'h0, imem_req}, 32'h1);
      chk("drain_addr", {16'h0, imem_addr}, 32'h5);
      chk("drain_inc", {31'h0, pc_inc}, 32'h0);
      tick(); ack_drv = 1'b0; #1;
      chk("drain_valid", {31'h0, instr_valid}, 32'h0);
      chk("target_addr", {16'h0, imem_addr}, 32'h40);
      tick(); ack_drv = 1'b1; #1;
      chk("target_inc", {31'h0, pc_inc}, 32'h1);
      tick(); ack_drv = 1'b0; #1;
      chk("target_valid", {31'h0, instr_valid}, 32'h1);
      chk("target_pc", {16'h0, instr_pc}, 32'h40);

      // reset while in REQ, late ack during reset
      tick(); reset = 1'b1; #1;
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      tick(); ack_drv = 1'b1; #1;
      chk("rst_ack_inc", {31'h0, pc_inc}, 32'h0);
      chk("rst_ack_valid", {31'h0, instr_valid}, 32'h0);
      tick(); ack_drv = 1'b0; #1;
      tick(); reset = 1'b0; #1;
      chk("post_rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("post_rst_addr", {16'h0, imem_addr}, 32'h0);
`ifdef IFETCH_PERF_EN
      chk("post_rst_perf", perf_fetched, 32'h0);
`endif
      tick(); #1;
      chk("post_rst_valid2", {31'h0, instr_valid}, 32'h0);

      // redirect coinciding with ack and pop
      do_reset();
      zero_wait = 1'b0; instr_ready = 1'b1;
      tick(); reset = 1'b0; ack_drv = 1'b1; #1;
      chk("rap_c0_inc", {31'h0, pc_inc}, 32'h1);
      tick(); ack_drv = 1'b0; instr_ready = 1'b0; #1;
      chk("rap_c1_valid", {31'h0, instr_valid}, 32'h1);
      chk("rap_c1_addr", {16'h0, imem_addr}, 32'h1);
      tick(); ack_drv = 1'b1; instr_ready = 1'b1; redirect = 1'b1; redirect_target = 16'h0080; #1;
      chk("rap_inc", {31'h0, pc_inc}, 32'h0);
      chk("rap_load", {31'h0, pc_load}, 32'h1);
      chk("rap_pc_in", {16'h0, pc_in}, 32'h80);
      tick(); ack_drv = 1'b0; redirect = 1'b0; #1;
      chk("rap_next_valid", {31'h0, instr_valid}, 32'h0);
      chk("rap_next_addr", {16'h0, imem_addr}, 32'h80);
      chk("rap_next_load", {31'h0, pc_load}, 32'h0);

      tick(); #3;
      chk("sb_drained", sb_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
